// File: rtl/clk_counter_leds_mode_ctrl.sv
// Button-driven display mode controller for the DE0-Nano green LEDs: owns the
// free-running clock counter and cycles COUNT -> PAUSE -> SCAN on each KEY[1] press.
module clk_counter_leds_mode_ctrl #(
  parameter int unsigned EXT_CLOCK_FREQ   = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned SCAN_TICK_CYCLES = 5_000_000
) (
  input  logic       EXTCLK,
  input  logic [1:0] KEY,
  output logic [7:0] LEDG
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_W = $clog2(SCAN_TICK_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICK_CYCLES - 1);

  if (EXT_CLOCK_FREQ == 0 || DEBOUNCE_CYCLES < 2 || SCAN_TICK_CYCLES < 1) begin : g_param_check
    $error("clk_counter_leds_mode_ctrl: illegal parameter values");
  end

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_PAUSE = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic              rst_n;
  logic              key_meta;
  logic              key_sync;
  logic              key_db;
  logic [DB_W-1:0]   db_cnt;
  logic              press;
  state_t            state_q;
  state_t            state_d;
  logic [31:0]       clk_counter;
  logic [2:0]        scan_pos;
  dir_t              scan_dir;
  logic [TICK_W-1:0] tick_cnt;
  logic              scan_tick;

  assign rst_n = KEY[0];

  // Synchronizer and debouncer; flops reset to the released level (1) so a
  // button held through reset must be re-qualified before it counts as a press.
  always_ff @(posedge EXTCLK or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      key_db   <= 1'b1;
      db_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let key_sync sample the old key_meta,
      // giving the two-stage synchronizer its intended delay.
      key_meta <= KEY[1];
      key_sync <= key_meta;
      if (key_sync == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Strobe on the same edge that commits a 1 -> 0 debounced transition.
  assign press     = (key_sync != key_db) && (db_cnt == DB_LAST) && !key_sync;
  assign scan_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge EXTCLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COUNT;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so every path drives state_d and no latch forms.
  always_comb begin
    state_d = state_q;
    if (press) begin
      case (state_q)
        ST_COUNT: state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_SCAN;
        ST_SCAN:  state_d = ST_COUNT;
        default:  state_d = ST_COUNT;
      endcase
    end
  end

  always_ff @(posedge EXTCLK or negedge rst_n) begin
    if (!rst_n) begin
      clk_counter <= '0;
      scan_pos    <= '0;
      scan_dir    <= DIR_UP;
      tick_cnt    <= '0;
      LEDG        <= '0;
    end else begin
      if (state_q != ST_PAUSE) clk_counter <= clk_counter + 32'd1;

      if (state_q == ST_PAUSE && press) begin
        scan_pos <= '0;
        scan_dir <= DIR_UP;
        tick_cnt <= '0;
      end else if (state_q == ST_SCAN && !press) begin
        // A press on a tick edge leaves SCAN, so that tick is dropped.
        if (scan_tick) begin
          tick_cnt <= '0;
          if (scan_dir == DIR_UP) begin
            if (scan_pos == 3'd7) begin
              scan_dir <= DIR_DOWN;
              scan_pos <= 3'd6;
            end else begin
              scan_pos <= scan_pos + 3'd1;
            end
          end else begin
            if (scan_pos == 3'd0) begin
              scan_dir <= DIR_UP;
              scan_pos <= 3'd1;
            end else begin
              scan_pos <= scan_pos - 3'd1;
            end
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      LEDG <= (state_q == ST_SCAN) ? (8'b1 << scan_pos) : clk_counter[31:24];
    end
  end

endmodule

// File: tb/tb_clk_counter_leds_mode_ctrl.sv
// Directed bench for clk_counter_leds_mode_ctrl with DEBOUNCE_CYCLES=4 and
// SCAN_TICK_CYCLES=3; expected values are hand-derived cycle by cycle.
module tb_clk_counter_leds_mode_ctrl;

  logic       EXTCLK;
  logic [1:0] KEY;
  logic [7:0] LEDG;

  int n_checks = 0;
  int n_errors = 0;

  localparam int ST_COUNT = 0;
  localparam int ST_PAUSE = 1;
  localparam int ST_SCAN  = 2;

  clk_counter_leds_mode_ctrl #(
    .EXT_CLOCK_FREQ  (50_000_000),
    .DEBOUNCE_CYCLES (4),
    .SCAN_TICK_CYCLES(3)
  ) dut (
    .EXTCLK(EXTCLK),
    .KEY   (KEY),
    .LEDG  (LEDG)
  );

  initial begin
    EXTCLK = 1'b0;
    forever #5 EXTCLK = ~EXTCLK;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Each call advances exactly n rising edges and returns on a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge EXTCLK);
  endtask

  // Full press: held 6 edges (state changes on the 6th), then released and settled.
  task automatic press_key();
    KEY[1] = 1'b0;
    cyc(6);
    KEY[1] = 1'b1;
    cyc(8);
  endtask

  logic [7:0] scan_exp [10];

  initial begin
    scan_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    KEY = 2'b10;
    cyc(3);
    check("rst_ledg", 32'(LEDG), 32'h0);
    check("rst_cnt", dut.clk_counter, 32'h0);
    check("rst_state", 32'(dut.state_q), ST_COUNT);
    KEY[0] = 1'b1;
    cyc(10);
    check("run_cnt", dut.clk_counter, 32'd10);

    // Reset asserted between edges must clear LEDG without a clock.
    force dut.clk_counter = 32'h7F00_0000;
    cyc(1);
    release dut.clk_counter;
    cyc(2);
    check("pre_rst_ledg", 32'(LEDG), 32'h7F);
    #2 KEY[0] = 1'b0;
    #1;
    check("async_rst_ledg", 32'(LEDG), 32'h0);
    check("async_rst_cnt", dut.clk_counter, 32'h0);
    @(negedge EXTCLK);
    KEY[0] = 1'b1;
    cyc(10);
    check("post_rst_cnt", dut.clk_counter, 32'd10);
    check("post_rst_ledg", 32'(LEDG), 32'h0);

    // Short glitch: 3 edges low is rejected.
    KEY[1] = 1'b0;
    cyc(3);
    KEY[1] = 1'b1;
    cyc(5);
    check("glitch_state", 32'(dut.state_q), ST_COUNT);
    check("glitch_cnt", dut.clk_counter, 32'd18);

    // Long press: 8 edges low gives exactly one transition on the 6th edge.
    KEY[1] = 1'b0;
    cyc(5);
    check("press_early_state", 32'(dut.state_q), ST_COUNT);
    cyc(1);
    check("press_state", 32'(dut.state_q), ST_PAUSE);
    check("press_cnt", dut.clk_counter, 32'd24);
    cyc(2);
    KEY[1] = 1'b1;
    cyc(8);
    check("one_press_state", 32'(dut.state_q), ST_PAUSE);
    check("pause_hold_cnt", dut.clk_counter, 32'd24);

    // PAUSE -> SCAN, walk the bounce pattern.
    KEY[1] = 1'b0;
    cyc(6);
    check("scan_state", 32'(dut.state_q), ST_SCAN);
    KEY[1] = 1'b1;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("scan_ledg%0d", i), 32'(LEDG), 32'(scan_exp[i]));
      if (i < 9) cyc(3);
    end
    check("scan_cnt", dut.clk_counter, 32'd52);

    // Press landing on a tick edge: press wins, scan_pos keeps its value.
    cyc(2);
    KEY[1] = 1'b0;
    cyc(6);
    check("scan_exit_state", 32'(dut.state_q), ST_COUNT);
    check("tick_dropped_pos", 32'(dut.scan_pos), 32'd3);
    check("scan_exit_cnt", dut.clk_counter, 32'd60);
    KEY[1] = 1'b1;
    cyc(8);
    check("count_again_cnt", dut.clk_counter, 32'd68);

    // Freeze at A5 in PAUSE.
    force dut.clk_counter = 32'hA500_0000;
    cyc(1);
    release dut.clk_counter;
    check("force_ledg", 32'(LEDG), 32'hA5);
    KEY[1] = 1'b0;
    cyc(6);
    check("pause2_state", 32'(dut.state_q), ST_PAUSE);
    KEY[1] = 1'b1;
    cyc(1);
    check("pause_ledg", 32'(LEDG), 32'hA5);
    check("pause_cnt", dut.clk_counter, 32'hA500_0006);
    cyc(100);
    check("pause100_ledg", 32'(LEDG), 32'hA5);
    check("pause100_cnt", dut.clk_counter, 32'hA500_0006);

    press_key();
    check("scan2_state", 32'(dut.state_q), ST_SCAN);
    press_key();
    check("count2_state", 32'(dut.state_q), ST_COUNT);
    check("scan_kept_counting", dut.clk_counter, 32'hA500_001C);

    // Wrap through zero.
    force dut.clk_counter = 32'hFFFF_FFFE;
    cyc(1);
    release dut.clk_counter;
    check("wrap_ledg0", 32'(LEDG), 32'hFF);
    cyc(1);
    check("wrap_ledg1", 32'(LEDG), 32'hFF);
    check("wrap_cnt1", dut.clk_counter, 32'hFFFF_FFFF);
    cyc(1);
    check("wrap_cnt2", dut.clk_counter, 32'h0);
    check("wrap_ledg2", 32'(LEDG), 32'hFF);
    cyc(1);
    check("wrap_ledg3", 32'(LEDG), 32'h00);

    // Reset in SCAN with the button held through release.
    press_key();
    press_key();
    check("scan3_state", 32'(dut.state_q), ST_SCAN);
    check("scan3_ledg", 32'(LEDG), 32'h04);
    KEY[1] = 1'b0;
    #2 KEY[0] = 1'b0;
    #1;
    check("scan_rst_ledg", 32'(LEDG), 32'h0);
    check("scan_rst_state", 32'(dut.state_q), ST_COUNT);
    check("scan_rst_pos", 32'(dut.scan_pos), 32'd0);
    @(negedge EXTCLK);
    cyc(2);
    KEY[0] = 1'b1;
    cyc(5);
    check("held_early_state", 32'(dut.state_q), ST_COUNT);
    check("held_early_cnt", dut.clk_counter, 32'd5);
    cyc(1);
    check("held_press_state", 32'(dut.state_q), ST_PAUSE);
    cyc(20);
    check("held_no_more_state", 32'(dut.state_q), ST_PAUSE);
    check("held_cnt", dut.clk_counter, 32'd6);
    KEY = 2'b11;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
